scene_cfg_scheduler: RTL and testbench
======================================

# scene_cfg_scheduler

Sits between the UART memflash receiver and the ray-tracer core. It decodes each completed flash write (one-cycle `flash_wen` pulse plus command byte and payload) and stages it. Camera, object-count and bounce-count updates are held in shadow registers and committed together only while the renderer is idle, so a frame never sees a partial update. Object writes are queued in a FIFO and drained into the single-port object BRAM, which the scheduler shares with renderer reads; renderer reads always have priority.

## Interface
- `OBJ_WIDTH`, 320: object record width in bits, matching the flash object payload.
- `CAM_WIDTH`, 96: width of one camera vector payload.
- `NUM_OBJS_WIDTH`, 8: object-count payload width.
- `OBJ_ADDR_WIDTH`, 7: object BRAM address width.
- `FIFO_DEPTH`, 4: number of pending object writes; a power of two, ≥ 2.
- `DEFAULT_BOUNCES`, 4: reset value of `max_bounces`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `flash_wen`  in  1  one-cycle strobe: the payload below is complete.
- `flash_cmd`  in  8  command byte.
- `flash_cam_data`  in  CAM_WIDTH  camera vector payload.
- `flash_obj_data`  in  OBJ_WIDTH  object payload.
- `flash_num_objs_data`  in  NUM_OBJS_WIDTH  object count payload.
- `flash_max_bounces_data`  in  8  bounce limit payload.
- `render_active`  in  1  renderer is mid-frame; high blocks commits and drains.
- `obj_rd_req`  in  1  renderer object read request.
- `obj_rd_addr`  in  OBJ_ADDR_WIDTH  renderer read address.
- `obj_rd_grant`  out  1  equals `obj_rd_req`; reads are never stalled.
- `mem_addr`  out  OBJ_ADDR_WIDTH  BRAM address.
- `mem_we`  out  1  BRAM write enable.
- `mem_wdata`  out  OBJ_WIDTH  BRAM write data.
- `cam_origin`, `cam_right`, `cam_forward`, `cam_up`  out  CAM_WIDTH each  active camera vectors.
- `num_objs`  out  NUM_OBJS_WIDTH  active object count.
- `max_bounces`  out  8  active bounce limit.
- `cfg_pending`  out  1  shadow registers are dirty, or the FIFO is non-empty.
- `obj_overflow`  out  1  sticky flag: an object write was dropped.

## Operation

**Command decode** (sampled only when `flash_wen` is high):
- `0aaaaaaa`: object write to address `a[OBJ_ADDR_WIDTH-1:0]`; pushes {addr, `flash_obj_data`} into the FIFO.
- `1????0vv`: shadow camera vector `vv` (00 origin, 01 right, 10 forward, 11 up) ← `flash_cam_data`.
- `1????100`: shadow `num_objs` ← payload.
- `1????101`: shadow `max_bounces` ← payload.
- `1????110` / `1????111`: ignored; no state change.
- Every accepted non-object command sets `dirty`.

**FIFO**
- A push when the FIFO is full drops the entry and sets `obj_overflow`.
- `obj_overflow` clears only on `rst`.

**FSM states**
- IDLE:
  - if `!render_active && dirty` → COMMIT;
  - else if `!render_active && fifo_nonempty` → DRAIN.
- COMMIT: copy all shadow registers to the active outputs. Clear `dirty` unless a new non-object `flash_wen` arrives in the same cycle; the new command lands in the shadow registers and `dirty` stays set. Return to IDLE.
- DRAIN: `mem_we = fifo_nonempty && !obj_rd_req && !render_active`, addressed at the FIFO head. Pop on each write cycle.
  - Exit to IDLE when the FIFO is empty or `render_active` is high.
  - If `dirty` becomes set while draining, go to IDLE; the next cycle enters COMMIT.

**BRAM port mux** (combinational from registered state)
- `mem_addr = obj_rd_req ? obj_rd_addr : fifo_head_addr`.
- `mem_wdata` = FIFO head data.
- `mem_we` is never high while `obj_rd_req` is high.

**Reset values**
- Active and shadow camera vectors: 0.
- `num_objs`: 0.
- `max_bounces`: `DEFAULT_BOUNCES`.
- FIFO empty, `dirty` = 0, state IDLE.
- All outputs low except `max_bounces`, and `obj_rd_grant`/`mem_addr`, which follow the renderer inputs.
- `rst` mid-drain discards queued writes; no write occurs in the reset cycle.

**Simultaneous push and pop**
- Allowed, including when the FIFO is full; the count is unchanged.
- A push onto an empty FIFO is writable no earlier than the next cycle.

## Timing
- Shadow registers and FIFO update on the edge where `flash_wen` is high.
- `dirty` and `cfg_pending` are visible the following cycle.
- Commit latency with `render_active` low: `flash_wen` at cycle N → IDLE sees `dirty` at N+1 → COMMIT at N+2 → active outputs change at edge N+3.
- Object write latency with the port idle: push at N → DRAIN at N+2 → `mem_we` high during N+2.
- Throughput is one write per cycle in DRAIN.
- `render_active` rising: blocks `mem_we` in the same cycle (combinational) and blocks COMMIT entry.
- `cfg_pending` is registered and falls the cycle after the last pop or commit.

## Test plan
1. Idle renderer; send cmd 0x81 with `flash_cam_data`=0x…ABCD → `cam_right` = 0x…ABCD three cycles after `flash_wen`; `cfg_pending` pulses high then returns to 0.
2. `render_active`=1; send 0x80, 0x84 (num_objs=5), 0x85 (bounces=7) → active outputs keep their reset values. Drop `render_active` → all three updates appear on the same edge.
3. Push 5 object writes (addr 0–4) while `render_active`=1 with `FIFO_DEPTH`=4 → `obj_overflow`=1; after release, exactly addresses 0–3 are written, in order, on consecutive cycles.
4. During a drain, assert `obj_rd_req` with `obj_rd_addr`=9 for 2 cycles → `mem_addr`=9 and `mem_we`=0 for those cycles; the drain then resumes with no entry lost.
5. `flash_wen` with cmd 0x82 in the COMMIT cycle → the new `cam_forward` value is committed on the next COMMIT; `dirty` never drops to 0 in between.
6. Assert `rst` with 3 queued objects → no `mem_we` afterwards; `max_bounces`=4; `cfg_pending`=0.

Source files
------------

// File: rtl/scene_cfg_scheduler.sv
// Stages flash-decoded scene configuration: shadow config committed atomically while the
// renderer is idle, and object writes queued and drained into the shared object BRAM.
module scene_cfg_scheduler #(
  parameter int unsigned OBJ_WIDTH       = 320,
  parameter int unsigned CAM_WIDTH       = 96,
  parameter int unsigned NUM_OBJS_WIDTH  = 8,
  parameter int unsigned OBJ_ADDR_WIDTH  = 7,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned DEFAULT_BOUNCES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flash_wen,
  input  logic [7:0]                flash_cmd,
  input  logic [CAM_WIDTH-1:0]      flash_cam_data,
  input  logic [OBJ_WIDTH-1:0]      flash_obj_data,
  input  logic [NUM_OBJS_WIDTH-1:0] flash_num_objs_data,
  input  logic [7:0]                flash_max_bounces_data,
  input  logic                      render_active,
  input  logic                      obj_rd_req,
  input  logic [OBJ_ADDR_WIDTH-1:0] obj_rd_addr,
  output logic                      obj_rd_grant,
  output logic [OBJ_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_we,
  output logic [OBJ_WIDTH-1:0]      mem_wdata,
  output logic [CAM_WIDTH-1:0]      cam_origin,
  output logic [CAM_WIDTH-1:0]      cam_right,
  output logic [CAM_WIDTH-1:0]      cam_forward,
  output logic [CAM_WIDTH-1:0]      cam_up,
  output logic [NUM_OBJS_WIDTH-1:0] num_objs,
  output logic [7:0]                max_bounces,
  output logic                      cfg_pending,
  output logic                      obj_overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_DRAIN} state_t;

  state_t                      state, state_nxt;
  logic                        commit;
  logic                        dirty, dirty_nxt;
  logic [OBJ_ADDR_WIDTH-1:0]   fifo_addr [FIFO_DEPTH];
  logic [OBJ_WIDTH-1:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [CNT_W-1:0]            count, count_nxt;
  logic                        fifo_nonempty, fifo_full;
  logic                        obj_cmd, cfg_cmd, push_ok, pop;
  logic [CAM_WIDTH-1:0]        sh_cam [4];
  logic [NUM_OBJS_WIDTH-1:0]   sh_num;
  logic [7:0]                  sh_bnc;

  // Command decode; 1????11x commands are ignored entirely
  assign obj_cmd = flash_wen && !flash_cmd[7];
  assign cfg_cmd = flash_wen && flash_cmd[7] && !(flash_cmd[2] && flash_cmd[1]);

  assign fifo_nonempty = (count != '0);
  assign fifo_full     = (count == CNT_W'(FIFO_DEPTH));
  assign pop           = mem_we;
  assign push_ok       = obj_cmd && (!fifo_full || pop);
  assign count_nxt     = count + CNT_W'(push_ok) - CNT_W'(pop);
  assign dirty_nxt     = cfg_cmd ? 1'b1 : (commit ? 1'b0 : dirty);

  // Renderer owns the port whenever it asks; the head entry is presented otherwise
  assign obj_rd_grant = obj_rd_req;
  assign mem_addr     = obj_rd_req ? obj_rd_addr :
                        (fifo_nonempty ? fifo_addr[rd_ptr] : '0);
  assign mem_wdata    = fifo_nonempty ? fifo_data[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!render_active && dirty)              state_nxt = ST_COMMIT;
        else if (!render_active && fifo_nonempty) state_nxt = ST_DRAIN;
      end
      ST_COMMIT: begin
        commit    = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        mem_we = fifo_nonempty && !obj_rd_req && !render_active && !rst;
        if (!fifo_nonempty || render_active || dirty) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FIFO storage needs no reset: entries are only read when the count says they are valid
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr[wr_ptr] <= flash_cmd[OBJ_ADDR_WIDTH-1:0];
      fifo_data[wr_ptr] <= flash_obj_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      dirty        <= 1'b0;
      cfg_pending  <= 1'b0;
      obj_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_nxt;
      dirty       <= dirty_nxt;
      cfg_pending <= dirty_nxt || (count_nxt != '0);
      if (obj_cmd && !push_ok) obj_overflow <= 1'b1;
    end
  end

  // Shadow and active config; commit samples the shadow before any same-cycle update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) sh_cam[i] <= '0;
      sh_num      <= '0;
      sh_bnc      <= 8'(DEFAULT_BOUNCES);
      cam_origin  <= '0;
      cam_right   <= '0;
      cam_forward <= '0;
      cam_up      <= '0;
      num_objs    <= '0;
      max_bounces <= 8'(DEFAULT_BOUNCES);
    end else begin
      if (cfg_cmd) begin
        case (flash_cmd[2:0])
          3'b100:  sh_num <= flash_num_objs_data;
          3'b101:  sh_bnc <= flash_max_bounces_data;
          default: sh_cam[flash_cmd[1:0]] <= flash_cam_data;
        endcase
      end
      if (commit) begin
        cam_origin  <= sh_cam[0];
        cam_right   <= sh_cam[1];
        cam_forward <= sh_cam[2];
        cam_up      <= sh_cam[3];
        num_objs    <= sh_num;
        max_bounces <= sh_bnc;
      end
    end
  end

endmodule

// File: tb/tb_scene_cfg_scheduler.sv
// Scoreboard bench for scene_cfg_scheduler: a queue of expected BRAM writes checked by a
// negedge monitor, plus a shadow/active config model checked at quiet points.
module tb_scene_cfg_scheduler;

  localparam int unsigned OBJ_WIDTH = 320;
  localparam int unsigned CAM_WIDTH = 96;
  localparam int unsigned NW        = 8;
  localparam int unsigned AW        = 7;
  localparam int unsigned DEPTH     = 4;

  typedef struct packed {
    logic [AW-1:0]        addr;
    logic [OBJ_WIDTH-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic flash_wen;
  logic [7:0] flash_cmd;
  logic [CAM_WIDTH-1:0] flash_cam_data;
  logic [OBJ_WIDTH-1:0] flash_obj_data;
  logic [NW-1:0] flash_num_objs_data;
  logic [7:0] flash_max_bounces_data;
  logic render_active, obj_rd_req;
  logic [AW-1:0] obj_rd_addr;
  logic obj_rd_grant, mem_we, cfg_pending, obj_overflow;
  logic [AW-1:0] mem_addr;
  logic [OBJ_WIDTH-1:0] mem_wdata;
  logic [CAM_WIDTH-1:0] cam_origin, cam_right, cam_forward, cam_up;
  logic [NW-1:0] num_objs;
  logic [7:0] max_bounces;

  scene_cfg_scheduler dut (
    .clk(clk), .rst(rst), .flash_wen(flash_wen), .flash_cmd(flash_cmd),
    .flash_cam_data(flash_cam_data), .flash_obj_data(flash_obj_data),
    .flash_num_objs_data(flash_num_objs_data), .flash_max_bounces_data(flash_max_bounces_data),
    .render_active(render_active), .obj_rd_req(obj_rd_req), .obj_rd_addr(obj_rd_addr),
    .obj_rd_grant(obj_rd_grant), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .cam_origin(cam_origin), .cam_right(cam_right), .cam_forward(cam_forward), .cam_up(cam_up),
    .num_objs(num_objs), .max_bounces(max_bounces), .cfg_pending(cfg_pending),
    .obj_overflow(obj_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;

  // Reference model: shadow config, expected active config, pending object writes
  logic [CAM_WIDTH-1:0] m_cam [4];
  logic [NW-1:0]        m_num;
  logic [7:0]           m_bnc;
  logic [CAM_WIDTH-1:0] e_cam [4];
  logic [NW-1:0]        e_num;
  logic [7:0]           e_bnc;
  logic                 exp_ovf;
  wr_t                  exp_q [$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OBJ_WIDTH-1:0] rand_obj();
    logic [OBJ_WIDTH-1:0] v;
    for (int i = 0; i < OBJ_WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [CAM_WIDTH-1:0] rand_cam();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_cam[i] = '0; e_cam[i] = '0; end
    m_num = '0; e_num = '0; m_bnc = 8'd4; e_bnc = 8'd4;
    exp_ovf = 1'b0;
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one flash command in the current cycle and apply it to the model
  task automatic set_cmd(input logic [7:0] cmd, input logic [CAM_WIDTH-1:0] cam,
                         input logic [OBJ_WIDTH-1:0] obj, input logic [NW-1:0] num,
                         input logic [7:0] bnc);
    wr_t e;
    flash_wen = 1'b1; flash_cmd = cmd; flash_cam_data = cam; flash_obj_data = obj;
    flash_num_objs_data = num; flash_max_bounces_data = bnc;
    if (!cmd[7]) begin
      if (exp_q.size() < DEPTH) begin
        e.addr = cmd[AW-1:0]; e.data = obj;
        exp_q.push_back(e);
      end else exp_ovf = 1'b1;
    end else begin
      case (cmd[2:0])
        3'd4:    m_num = num;
        3'd5:    m_bnc = bnc;
        3'd6, 3'd7: ;
        default: m_cam[cmd[1:0]] = cam;
      endcase
    end
  endtask

  task automatic send(input logic [7:0] cmd, input logic [CAM_WIDTH-1:0] cam,
                      input logic [OBJ_WIDTH-1:0] obj, input logic [NW-1:0] num,
                      input logic [7:0] bnc);
    tick();
    set_cmd(cmd, cam, obj, num, bnc);
  endtask

  task automatic idle();
    tick();
    flash_wen = 1'b0;
  endtask

  task automatic settle_check(input string tag);
    tick();
    flash_wen = 1'b0; render_active = 1'b0; obj_rd_req = 1'b0;
    repeat (16) tick();
    @(negedge clk);
    chk({tag, ".cam_origin"}, cam_origin, m_cam[0]);
    chk({tag, ".cam_right"}, cam_right, m_cam[1]);
    chk({tag, ".cam_forward"}, cam_forward, m_cam[2]);
    chk({tag, ".cam_up"}, cam_up, m_cam[3]);
    chk({tag, ".num_objs"}, num_objs, m_num);
    chk({tag, ".max_bounces"}, max_bounces, m_bnc);
    chk({tag, ".cfg_pending"}, cfg_pending, 1'b0);
    chk({tag, ".obj_overflow"}, obj_overflow, exp_ovf);
    chk({tag, ".writes_left"}, exp_q.size(), 0);
    for (int i = 0; i < 4; i++) e_cam[i] = m_cam[i];
    e_num = m_num; e_bnc = m_bnc;
  endtask

  // Monitor: every BRAM-port cycle is checked against the scoreboard
  always @(negedge clk) begin : monitor
    wr_t e;
    if (mon_en && !rst) begin
      chk("rd_grant", obj_rd_grant, obj_rd_req);
      if (obj_rd_req) chk("rd_addr", mem_addr, obj_rd_addr);
      if (mem_we) begin
        chk("we_blocked", {obj_rd_req, render_active}, 2'b00);
        if (exp_q.size() == 0) chk("spurious_write", mem_we, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CAM_WIDTH-1:0] ca, cb;
    logic found;
    rst = 1'b1; flash_wen = 1'b0; flash_cmd = '0; flash_cam_data = '0; flash_obj_data = '0;
    flash_num_objs_data = '0; flash_max_bounces_data = '0;
    render_active = 1'b0; obj_rd_req = 1'b0; obj_rd_addr = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst.max_bounces", max_bounces, 8'd4);
    chk("rst.cam_origin", cam_origin, '0);
    chk("rst.num_objs", num_objs, '0);
    chk("rst.cfg_pending", cfg_pending, 1'b0);
    chk("rst.obj_overflow", obj_overflow, 1'b0);
    chk("rst.mem_we", mem_we, 1'b0);

    // Commit latency: new value on the third edge after the strobe
    ca = rand_cam();
    send(8'h81, ca, '0, '0, '0);
    idle(); @(negedge clk);
    chk("lat.pending_n1", cfg_pending, 1'b1);
    chk("lat.right_n1", cam_right, '0);
    idle(); @(negedge clk);
    chk("lat.pending_n2", cfg_pending, 1'b1);
    chk("lat.right_n2", cam_right, '0);
    idle(); @(negedge clk);
    chk("lat.pending_n3", cfg_pending, 1'b0);
    chk("lat.right_n3", cam_right, ca);
    settle_check("t1");

    // Updates held during a frame then committed together
    tick(); render_active = 1'b1;
    send(8'h80, rand_cam(), '0, '0, '0);
    send(8'h84, '0, '0, 8'd5, '0);
    send(8'h85, '0, '0, '0, 8'd7);
    idle(); render_active = 1'b1;
    repeat (3) idle();
    @(negedge clk);
    chk("hold.cam_origin", cam_origin, e_cam[0]);
    chk("hold.num_objs", num_objs, e_num);
    chk("hold.max_bounces", max_bounces, e_bnc);
    tick(); render_active = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (cam_origin !== e_cam[0] || num_objs !== e_num || max_bounces !== e_bnc) begin
        found = 1'b1;
        chk("same_edge.cam_origin", cam_origin, m_cam[0]);
        chk("same_edge.num_objs", num_objs, m_num);
        chk("same_edge.max_bounces", max_bounces, m_bnc);
      end
      tick();
    end
    chk("same_edge.seen", found, 1'b1);
    settle_check("t2");

    // Command landing in the COMMIT cycle is committed on the following COMMIT
    ca = rand_cam(); cb = rand_cam();
    send(8'h81, ca, '0, '0, '0);
    idle();
    send(8'h82, cb, '0, '0, '0);
    idle(); @(negedge clk);
    chk("recommit.pending_n3", cfg_pending, 1'b1);
    chk("recommit.right_n3", cam_right, ca);
    chk("recommit.fwd_n3", cam_forward, e_cam[2]);
    idle(); @(negedge clk);
    chk("recommit.pending_n4", cfg_pending, 1'b1);
    chk("recommit.fwd_n4", cam_forward, e_cam[2]);
    idle(); @(negedge clk);
    chk("recommit.fwd_n5", cam_forward, cb);
    chk("recommit.pending_n5", cfg_pending, 1'b0);
    settle_check("t5");

    // Randomized traffic, never pushing past what the model knows is free
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 100; c++) begin
        tick();
        flash_wen = 1'b0;
        if ($urandom_range(9) == 0) render_active = ~render_active;
        obj_rd_req = ($urandom_range(3) == 0);
        obj_rd_addr = AW'($urandom);
        if ($urandom_range(2) == 0) begin
          if ($urandom_range(1) == 0 && exp_q.size() < DEPTH)
            set_cmd({1'b0, 7'($urandom)}, '0, rand_obj(), '0, '0);
          else
            set_cmd({1'b1, 4'($urandom), 3'($urandom)}, rand_cam(), '0,
                    NW'($urandom), 8'($urandom));
        end
      end
      settle_check("rand");
    end

    // Overflow: fifth push dropped, first four drained back to back
    tick(); render_active = 1'b1;
    for (int a = 0; a < 5; a++) send({1'b0, 7'(a)}, '0, rand_obj(), '0, '0);
    idle(); @(negedge clk);
    chk("ovf.flag", obj_overflow, 1'b1);
    tick(); render_active = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ovf.consecutive_we", mem_we, 1'b1);
      tick();
    end
    settle_check("t3");

    // Renderer reads interrupt a drain without losing entries
    tick(); render_active = 1'b1;
    for (int a = 20; a < 24; a++) send({1'b0, 7'(a)}, '0, rand_obj(), '0, '0);
    idle(); render_active = 1'b0;
    tick();
    tick(); obj_rd_req = 1'b1; obj_rd_addr = 7'd9;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rdint.mem_addr", mem_addr, 7'd9);
      chk("rdint.mem_we", mem_we, 1'b0);
      tick();
    end
    obj_rd_req = 1'b0;
    settle_check("t4");

    // Reset mid-drain discards queued writes
    tick(); render_active = 1'b1;
    for (int a = 40; a < 43; a++) send({1'b0, 7'(a)}, '0, rand_obj(), '0, '0);
    send(8'h85, '0, '0, '0, 8'd9);
    idle(); render_active = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rstmid.mem_we", mem_we, 1'b0);
    tick(); rst = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("rstmid.max_bounces", max_bounces, 8'd4);
    chk("rstmid.cfg_pending", cfg_pending, 1'b0);
    chk("rstmid.obj_overflow", obj_overflow, 1'b0);
    chk("rstmid.num_objs", num_objs, '0);
    chk("rstmid.cam_right", cam_right, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
